// File: rtl/fm_pkg.sv
// Shared types and default NCO phase words (50 MHz clock, 32-bit accumulator).
package fm_pkg;

    typedef enum logic {IDLE, SYMBOL} state_t;

    localparam logic [31:0] TONE_4M95 = 32'd425201762;
    localparam logic [31:0] TONE_5M   = 32'd429496730;
    localparam logic [31:0] TONE_5M05 = 32'd433791697;
    localparam logic [31:0] TONE_10M  = 32'd858993459;

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO; one extra pointer bit separates full from empty.
module sym_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mfsk_tone_sequencer.sv
// Buffered MFSK symbol sequencer: pops tone indices, holds each for a symbol
// period and drives an NCO phase increment, optionally slew-limited.
module mfsk_tone_sequencer
    import fm_pkg::*;
#(
    parameter int PHASE_WIDTH   = 32,
    parameter int NUM_TONES     = 4,
    parameter int SYMBOL_CYCLES = 50000,
    parameter int FIFO_DEPTH    = 8,
    parameter logic [PHASE_WIDTH-1:0] RAMP_STEP = PHASE_WIDTH'(1048576),
    parameter logic [PHASE_WIDTH-1:0] IDLE_WORD = PHASE_WIDTH'(TONE_5M),
    localparam int SYM_W = $clog2(NUM_TONES),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [SYM_W-1:0]                 sym_i,
    input  logic                             sym_valid_i,
    output logic                             sym_ready_o,
    input  logic [NUM_TONES*PHASE_WIDTH-1:0] tone_table_i,
    input  logic                             ramp_en_i,
    output logic [PHASE_WIDTH-1:0]           phase_inc_o,
    output logic                             busy_o,
    output logic                             symbol_done_o,
    output logic [LVL_W-1:0]                 fifo_level_o
);
    localparam int CNT_W = $clog2(SYMBOL_CYCLES);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0]  target_q, target_d, phase_q, phase_d;
    logic [SYM_W-1:0]        fifo_head;
    logic                    fifo_empty, fifo_full, pop, last;
    logic [NUM_TONES-1:0][PHASE_WIDTH-1:0] tone_tab;

    assign tone_tab    = tone_table_i;
    assign sym_ready_o = !fifo_full;
    assign busy_o      = (state_q == SYMBOL);
    assign phase_inc_o = phase_q;
    assign last        = (cnt_q == CNT_W'(SYMBOL_CYCLES - 1));

    sym_fifo #(.WIDTH(SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (sym_valid_i && sym_ready_o),
        .wr_data (sym_i),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level_o)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        pop           = 1'b0;
        symbol_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    target_d = tone_tab[fifo_head];
                    cnt_d    = '0;
                    state_d  = SYMBOL;
                end else begin
                    target_d = IDLE_WORD;
                end
            end
            SYMBOL: begin
                if (!last) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    symbol_done_o = 1'b1;
                    cnt_d         = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        target_d = tone_tab[fifo_head];
                    end else begin
                        target_d = IDLE_WORD;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slew toward the target being loaded this edge; distance is checked
    // before stepping so the add/subtract can never wrap or overshoot.
    always_comb begin
        phase_d = target_d;
        if (ramp_en_i) begin
            if (target_d >= phase_q)
                phase_d = (target_d - phase_q > RAMP_STEP) ? phase_q + RAMP_STEP : target_d;
            else
                phase_d = (phase_q - target_d > RAMP_STEP) ? phase_q - RAMP_STEP : target_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= IDLE_WORD;
            phase_q  <= IDLE_WORD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            phase_q  <= phase_d;
        end
    end

endmodule

// File: tb/tb_mfsk_tone_sequencer.sv
// Directed bench: dut_a (4-cycle symbols) runs the vector table and reset
// cases; dut_b (16-cycle symbols, coarse ramp) covers FIFO fill and slewing.
module tb_mfsk_tone_sequencer;
    localparam logic [31:0] T0 = 32'd425201762;
    localparam logic [31:0] T1 = 32'd433791697;
    localparam logic [31:0] T2 = 32'd429496730;
    localparam logic [31:0] T3 = 32'd858993459;
    localparam logic [31:0] IW = 32'd429496730;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] tone_table = {T3, T2, T1, T0};
    logic [1:0]   sym_a = '0, sym_b = '0;
    logic         valid_a = 1'b0, valid_b = 1'b0, ramp_a = 1'b0, ramp_b = 1'b0;
    logic         ready_a, ready_b, busy_a, busy_b, done_a, done_b;
    logic [31:0]  phase_a, phase_b;
    logic [3:0]   level_a, level_b;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    mfsk_tone_sequencer #(.SYMBOL_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .sym_i(sym_a), .sym_valid_i(valid_a),
        .sym_ready_o(ready_a), .tone_table_i(tone_table), .ramp_en_i(ramp_a),
        .phase_inc_o(phase_a), .busy_o(busy_a), .symbol_done_o(done_a),
        .fifo_level_o(level_a)
    );

    mfsk_tone_sequencer #(.SYMBOL_CYCLES(16), .RAMP_STEP(32'd100000000)) dut_b (
        .clk(clk), .reset_n(reset_n), .sym_i(sym_b), .sym_valid_i(valid_b),
        .sym_ready_o(ready_b), .tone_table_i(tone_table), .ramp_en_i(ramp_b),
        .phase_inc_o(phase_b), .busy_o(busy_b), .symbol_done_o(done_b),
        .fifo_level_o(level_b)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  sym;
        logic [31:0] phase;
        logic        done;
        logic        busy;
        logic [3:0]  level;
        logic        ready;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_a = 1'b0;
        valid_b = 1'b0;
        ramp_a  = 1'b0;
        ramp_b  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int ramp_exp[6];
        ramp_exp = '{529496730, 629496730, 729496730, 829496730, 858993459, 858993459};

        // single symbol 1, then symbols 0,3 back-to-back
        vecs[0]  = '{1'b1, 2'd1, IW, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[1]  = '{1'b0, 2'd0, T1, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[2]  = '{1'b0, 2'd0, T1, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[3]  = '{1'b0, 2'd0, T1, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, T1, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, IW, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, IW, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[7]  = '{1'b1, 2'd0, IW, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[8]  = '{1'b1, 2'd3, T0, 1'b0, 1'b1, 4'd1, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, T0, 1'b0, 1'b1, 4'd1, 1'b1};
        vecs[10] = '{1'b0, 2'd0, T0, 1'b0, 1'b1, 4'd1, 1'b1};
        vecs[11] = '{1'b0, 2'd0, T0, 1'b1, 1'b1, 4'd1, 1'b1};
        vecs[12] = '{1'b0, 2'd0, T3, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[13] = '{1'b0, 2'd0, T3, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[14] = '{1'b0, 2'd0, T3, 1'b0, 1'b1, 4'd0, 1'b1};
        vecs[15] = '{1'b0, 2'd0, T3, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[16] = '{1'b0, 2'd0, IW, 1'b0, 1'b0, 4'd0, 1'b1};

        // reset state
        tick();
        chk("rst phase_a", phase_a, IW);
        chk("rst busy_a", 32'(busy_a), 0);
        chk("rst done_a", 32'(done_a), 0);
        chk("rst ready_a", 32'(ready_a), 1);
        chk("rst level_a", 32'(level_a), 0);
        chk("rst phase_b", phase_b, IW);
        chk("rst level_b", 32'(level_b), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            valid_a = vecs[i].valid;
            sym_a   = vecs[i].sym;
            tick();
            chk($sformatf("v%0d phase", i), phase_a, vecs[i].phase);
            chk($sformatf("v%0d done", i), 32'(done_a), 32'(vecs[i].done));
            chk($sformatf("v%0d busy", i), 32'(busy_a), 32'(vecs[i].busy));
            chk($sformatf("v%0d level", i), 32'(level_a), 32'(vecs[i].level));
            chk($sformatf("v%0d ready", i), 32'(ready_a), 32'(vecs[i].ready));
        end
        valid_a = 1'b0;

        // fill: first symbol pops at once, eight more sit behind the long symbol
        do_reset();
        valid_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sym_b = 2'(i);
            tick();
            if (i == 7) begin
                chk("fill7 level", 32'(level_b), 7);
                chk("fill7 ready", 32'(ready_b), 1);
            end
            if (i >= 8) begin
                chk($sformatf("fill%0d level", i), 32'(level_b), 8);
                chk($sformatf("fill%0d ready", i), 32'(ready_b), 0);
            end
        end
        valid_b = 1'b0;

        // ramp from idle word to tone 3
        do_reset();
        ramp_b  = 1'b1;
        valid_b = 1'b1;
        sym_b   = 2'd3;
        tick();
        valid_b = 1'b0;
        chk("ramp push phase", phase_b, IW);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("ramp%0d phase", j), phase_b, 32'(ramp_exp[j]));
        end

        // ramp disabled mid-slew snaps to target
        do_reset();
        ramp_b  = 1'b1;
        valid_b = 1'b1;
        sym_b   = 2'd3;
        tick();
        valid_b = 1'b0;
        tick();
        tick();
        chk("snap pre phase", phase_b, 32'd629496730);
        ramp_b = 1'b0;
        tick();
        chk("snap phase", phase_b, T3);

        // reset at cnt_q = 2 with three symbols buffered
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid_a = 1'b1;
            sym_a   = 2'(i);
            tick();
            chk($sformatf("mid%0d done", i), 32'(done_a), 0);
        end
        valid_a = 1'b0;
        chk("mid level", 32'(level_a), 3);
        chk("mid busy", 32'(busy_a), 1);
        chk("mid phase", phase_a, T0);
        reset_n = 1'b0;
        tick();
        chk("midrst phase", phase_a, IW);
        chk("midrst level", 32'(level_a), 0);
        chk("midrst busy", 32'(busy_a), 0);
        chk("midrst done", 32'(done_a), 0);
        chk("midrst ready", 32'(ready_a), 1);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post%0d done", i), 32'(done_a), 0);
            chk($sformatf("post%0d busy", i), 32'(busy_a), 0);
            chk($sformatf("post%0d phase", i), phase_a, IW);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
